cpu_irq_sequencer: RTL and testbench
====================================

// Module: cpu_irq_sequencer
// PURPOSE
//  Parametrised reset/NMI/IRQ/BRK sequencer for the 6502 core. Owns the memory bus while busy.
//  Sequence: push PCH, PCL, P to stack; fetch 16-bit vector; load PC/SP; set I.
//  Supports NUM_IRQ masked level IRQ channels with optional per-channel vectors (VECTORED).
//  Sits beside cpu_control_unit; the control unit stalls while seq_busy=1.
// PARAMETERS
//  NUM_IRQ       4        number of IRQ channels (1..8)
//  VECTORED      0        0: all IRQ/BRK use IRQ_VEC; 1: IRQ ch i uses IRQ_VEC_BASE+2*i, BRK uses IRQ_VEC
//  STACK_PAGE    8'h01    high byte of stack address
//  NMI_VEC       16'hFFFA NMI vector address
//  RST_VEC       16'hFFFC reset vector address
//  IRQ_VEC       16'hFFFE IRQ/BRK vector address
//  IRQ_VEC_BASE  16'hFFE0 channel-0 vector address when VECTORED=1
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous active-high reset
//  irq_n          in   NUM_IRQ  active-low level interrupt requests
//  irq_mask       in   NUM_IRQ  1 = channel enabled
//  nmi_n          in   1        active-low NMI (falling-edge sensitive)
//  brk_req        in   1        1-cycle pulse from control unit on BRK execute
//  i_flag         in   1        status I flag
//  insn_boundary  in   1        control unit at instruction fetch; sequences may start
//  pc_in          in   16       return address to push
//  p_in           in   8        status value to push
//  sp_in          in   8        current stack pointer
//  mem_addr       out  16       bus address
//  mem_data_out   out  8        write data
//  mem_read       out  1        read strobe
//  mem_write      out  1        write strobe
//  mem_ready      in   1        access completes on clk edge where strobe && mem_ready
//  mem_data_in    in   8        read data (valid with mem_ready)
//  seq_busy       out  1        sequencer owns bus / core must stall
//  pc_load        out  1        1-cycle: load PC with pc_load_value
//  pc_load_value  out  16       new PC
//  sp_load        out  1        1-cycle (with pc_load): load SP with sp_out
//  sp_out         out  8        new SP
//  set_i          out  1        1-cycle (with pc_load): set I flag
//  irq_ack        out  NUM_IRQ  one-hot 1-cycle pulse in LOAD for serviced channel
//  active_src     out  2        0 reset, 1 NMI, 2 IRQ, 3 BRK (valid while seq_busy)
// BEHAVIOUR
//  - rst=1: all outputs 0, pending NMI/BRK cleared; state <= RST_LO.
//    First cycle after release: seq_busy=1.
//  - States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD, RST_LO, RST_HI.
//  - NMI: falling edge of nmi_n (registered previous value) sets nmi_pending.
//    Cleared on acceptance; an edge during a sequence stays pending.
//  - BRK: brk_req sets brk_pending; cleared on acceptance.
//  - IRQ pend = ~irq_n & irq_mask; eligible only if i_flag=0; lowest index wins.
//    Channel captured at acceptance; completes even if irq_n deasserts.
//  - Acceptance in IDLE when insn_boundary=1. Priority NMI > BRK > IRQ.
//    Internal sp <= sp_in, go to PUSH_PCH.
//  - Each access state holds addr/data/strobe constant until mem_ready=1, then advances.
//    Exactly one strobe active.
//  - Push addr = {STACK_PAGE, sp}; sp decrements (8-bit wrap 00->FF) after each completed push.
//  - Push order: pc_in[15:8], pc_in[7:0], P. BRK pushes p_in|8'h30.
//    NMI/IRQ push (p_in & 8'hEF)|8'h20.
//  - VEC_LO reads vec, VEC_HI reads vec+1 (16-bit wrap). Reset path: RST_LO/RST_HI on RST_VEC, no pushes.
//  - LOAD (1 cycle, no strobe): pc_load=1, pc_load_value={hi,lo}, sp_load=1, set_i=1.
//    sp_out = sp_in-3 (reset: 8'hFD). irq_ack for IRQ only. Then IDLE, seq_busy=0.
//  - Latency with mem_ready=1: pc_load high 6 cycles after accepting edge (reset: 3 after release).
//    Each mem_ready=0 cycle adds 1.
//  - rst mid-sequence: abort immediately, no further writes, restart at RST_LO.
// TESTING
//  - Reset: release rst, mem FFFC=00, FFFD=80 -> reads FFFC, FFFD; pc_load_value=8000, sp_out=FD, set_i=1.
//  - NMI: pc_in=1234, p_in=21, sp_in=FF, nmi_n 1->0 -> writes 12@01FF, 34@01FE, 21@01FD.
//    Reads FFFA/FFFB; sp_out=FC.
//  - IRQ mask: irq_n[2]=0, i_flag=1 -> no start. i_flag=0, VECTORED=1 -> reads FFE4/FFE5.
//    P pushed with bit4=0; irq_ack=4'b0100.
//  - Priority: NMI edge + brk_req + irq same boundary -> NMI first (P bit4=0).
//    Next boundary BRK (P bit4=1, IRQ_VEC); IRQ blocked by I.
//  - Wait states: mem_ready low 3 cycles on PUSH_PCL -> addr 01FE/data held; pc_load at 9 cycles.
//  - Reset mid-op: assert rst during PUSH_P -> no write to 01FD; after release restart at FFFC.

Source files
------------

// File: rtl/cpu_irq_sequencer.sv
// Reset/NMI/IRQ/BRK entry sequencer for the 6502 core: pushes PC and P, fetches the
// vector, then hands new PC/SP/I back to the core. Owns the memory bus while busy.
module cpu_irq_sequencer #(
    parameter int          NUM_IRQ      = 4,
    parameter bit          VECTORED     = 1'b0,
    parameter logic [7:0]  STACK_PAGE   = 8'h01,
    parameter logic [15:0] NMI_VEC      = 16'hFFFA,
    parameter logic [15:0] RST_VEC      = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC      = 16'hFFFE,
    parameter logic [15:0] IRQ_VEC_BASE = 16'hFFE0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               nmi_n,
    input  logic               brk_req,
    input  logic               i_flag,
    input  logic               insn_boundary,
    input  logic [15:0]        pc_in,
    input  logic [7:0]         p_in,
    input  logic [7:0]         sp_in,
    output logic [15:0]        mem_addr,
    output logic [7:0]         mem_data_out,
    output logic               mem_read,
    output logic               mem_write,
    input  logic               mem_ready,
    input  logic [7:0]         mem_data_in,
    output logic               seq_busy,
    output logic               pc_load,
    output logic [15:0]        pc_load_value,
    output logic               sp_load,
    output logic [7:0]         sp_out,
    output logic               set_i,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [1:0]         active_src
);
    typedef enum logic [3:0] {
        IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD, RST_LO, RST_HI
    } state_t;

    localparam logic [1:0] SRC_RST = 2'd0, SRC_NMI = 2'd1, SRC_IRQ = 2'd2, SRC_BRK = 2'd3;

    state_t       state, state_nx;
    logic [7:0]   sp, p_r, vec_lo, vec_hi;
    logic [15:0]  pc_r, vec;
    logic [1:0]   src, acc_src;
    logic [2:0]   ch, irq_sel;
    logic         nmi_prev, nmi_pend, brk_pend;
    logic         nmi_any, brk_any, irq_any, accept;
    logic [15:0]  acc_vec;
    logic [NUM_IRQ-1:0] irq_pend;

    // A same-cycle edge or pulse may be accepted directly, without waiting for the pending flop.
    assign nmi_any  = nmi_pend | (nmi_prev & ~nmi_n);
    assign brk_any  = brk_pend | brk_req;
    assign irq_pend = ~irq_n & irq_mask & {NUM_IRQ{~i_flag}};
    assign irq_any  = |irq_pend;
    assign accept   = (state == IDLE) && insn_boundary && (nmi_any || brk_any || irq_any);

    always_comb begin
        irq_sel = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (irq_pend[i]) irq_sel = 3'(i);
    end

    always_comb begin
        acc_src = nmi_any ? SRC_NMI : (brk_any ? SRC_BRK : SRC_IRQ);
        case (acc_src)
            SRC_NMI: acc_vec = NMI_VEC;
            SRC_IRQ: acc_vec = VECTORED ? IRQ_VEC_BASE + {12'd0, irq_sel, 1'b0} : IRQ_VEC;
            default: acc_vec = IRQ_VEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RST_LO;
            sp       <= 8'hFD;
            src      <= SRC_RST;
            vec      <= RST_VEC;
            ch       <= 3'd0;
            pc_r     <= 16'd0;
            p_r      <= 8'd0;
            vec_lo   <= 8'd0;
            vec_hi   <= 8'd0;
            nmi_pend <= 1'b0;
            brk_pend <= 1'b0;
            nmi_prev <= nmi_n;
        end else begin
            state    <= state_nx;
            nmi_prev <= nmi_n;
            if (accept && acc_src == SRC_NMI) nmi_pend <= 1'b0;
            else if (nmi_prev && !nmi_n)       nmi_pend <= 1'b1;
            if (accept && acc_src == SRC_BRK) brk_pend <= 1'b0;
            else if (brk_req)                  brk_pend <= 1'b1;
            if (accept) begin
                src  <= acc_src;
                ch   <= irq_sel;
                pc_r <= pc_in;
                p_r  <= p_in;
                sp   <= sp_in;
                vec  <= acc_vec;
            end
            if (mem_ready) begin
                case (state)
                    PUSH_PCH, PUSH_PCL, PUSH_P: sp <= 8'(sp - 8'd1);
                    VEC_LO, RST_LO:             vec_lo <= mem_data_in;
                    VEC_HI, RST_HI:             vec_hi <= mem_data_in;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept)    state_nx = PUSH_PCH;
            PUSH_PCH: if (mem_ready) state_nx = PUSH_PCL;
            PUSH_PCL: if (mem_ready) state_nx = PUSH_P;
            PUSH_P:   if (mem_ready) state_nx = VEC_LO;
            VEC_LO:   if (mem_ready) state_nx = VEC_HI;
            VEC_HI:   if (mem_ready) state_nx = LOAD;
            RST_LO:   if (mem_ready) state_nx = RST_HI;
            RST_HI:   if (mem_ready) state_nx = LOAD;
            LOAD:                    state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    // Outputs are forced low whenever rst is high so an abort drops the strobe at once.
    always_comb begin
        mem_addr      = 16'd0;
        mem_data_out  = 8'd0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        seq_busy      = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 16'd0;
        sp_load       = 1'b0;
        sp_out        = 8'd0;
        set_i         = 1'b0;
        irq_ack       = '0;
        active_src    = 2'd0;
        if (!rst) begin
            seq_busy   = (state != IDLE);
            active_src = src;
            case (state)
                PUSH_PCH: begin
                    mem_write = 1'b1; mem_addr = {STACK_PAGE, sp}; mem_data_out = pc_r[15:8];
                end
                PUSH_PCL: begin
                    mem_write = 1'b1; mem_addr = {STACK_PAGE, sp}; mem_data_out = pc_r[7:0];
                end
                PUSH_P: begin
                    mem_write    = 1'b1;
                    mem_addr     = {STACK_PAGE, sp};
                    mem_data_out = (src == SRC_BRK) ? (p_r | 8'h30) : ((p_r & 8'hEF) | 8'h20);
                end
                VEC_LO, RST_LO: begin mem_read = 1'b1; mem_addr = vec; end
                VEC_HI, RST_HI: begin mem_read = 1'b1; mem_addr = 16'(vec + 16'd1); end
                LOAD: begin
                    pc_load       = 1'b1;
                    pc_load_value = {vec_hi, vec_lo};
                    sp_load       = 1'b1;
                    sp_out        = sp;
                    set_i         = 1'b1;
                    if (src == SRC_IRQ) irq_ack = NUM_IRQ'(1) << ch;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_irq_sequencer.sv
// Directed bench for cpu_irq_sequencer: bus accesses and PC/SP loads are queued as
// expectations when stimulus is driven and checked as the sequencer produces them.
module tb_cpu_irq_sequencer;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst, nmi_n, brk_req, i_flag, insn_boundary, mem_ready;
    logic [N-1:0]  irq_n, irq_mask, irq_ack;
    logic [15:0]   pc_in, mem_addr, pc_load_value;
    logic [7:0]    p_in, sp_in, mem_data_out, mem_data_in, sp_out;
    logic          mem_read, mem_write, seq_busy, pc_load, sp_load, set_i;
    logic [1:0]    active_src;

    cpu_irq_sequencer #(.NUM_IRQ(N), .VECTORED(1'b1)) dut (
        .clk(clk), .rst(rst), .irq_n(irq_n), .irq_mask(irq_mask), .nmi_n(nmi_n),
        .brk_req(brk_req), .i_flag(i_flag), .insn_boundary(insn_boundary),
        .pc_in(pc_in), .p_in(p_in), .sp_in(sp_in), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ready(mem_ready), .mem_data_in(mem_data_in), .seq_busy(seq_busy),
        .pc_load(pc_load), .pc_load_value(pc_load_value), .sp_load(sp_load),
        .sp_out(sp_out), .set_i(set_i), .irq_ack(irq_ack), .active_src(active_src)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; logic [15:0] addr; logic [7:0] data; } bus_t;
    typedef struct { logic [15:0] pc; logic [7:0] sp; logic [N-1:0] ack; logic [1:0] src; } load_t;

    bus_t  bus_q[$];
    load_t load_q[$];
    logic [7:0] mem [0:65535];
    int total = 0, bad = 0, cyc = 0;
    int hold_cnt = 0, load_cyc = 0, pl, a;
    bit abort_en = 1'b0, got_load = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_bus(input bit wr, input logic [15:0] addr, input logic [7:0] data);
        bus_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        bus_q.push_back(e);
    endtask

    task automatic exp_load(input logic [15:0] pc, input logic [7:0] sp,
                            input logic [N-1:0] ack, input logic [1:0] src);
        load_t e;
        e.pc = pc; e.sp = sp; e.ack = ack; e.src = src;
        load_q.push_back(e);
    endtask

    // One clock: respond/check at negedge, return just after the next posedge.
    task automatic step();
        bus_t  b;
        load_t l;
        @(negedge clk);
        if (hold_cnt > 0 && mem_write && mem_addr == 16'h01FE) begin
            mem_ready = 1'b0;
            hold_cnt--;
            chk("hold_data", {8'h0, mem_data_out}, 32'h34);
        end else begin
            mem_ready = 1'b1;
        end
        if (abort_en && mem_write && mem_addr == 16'h01FD) begin
            rst = 1'b1;
            abort_en = 1'b0;
            #1;
            chk("abort_nowrite", {31'd0, mem_write}, 32'd0);
            chk("abort_busy", {31'd0, seq_busy}, 32'd0);
        end
        mem_data_in = mem[mem_addr];
        if (mem_read && mem_write) chk("one_strobe", 32'd1, 32'd0);
        if ((mem_read || mem_write) && mem_ready) begin
            total++;
            assert (bus_q.size() > 0) else begin
                bad++;
                $error("FAIL bus_unexpected observed=%0h expected=none", mem_addr);
            end
            if (bus_q.size() > 0) begin
                b = bus_q.pop_front();
                chk("bus_wr", {31'd0, mem_write}, {31'd0, b.wr});
                chk("bus_addr", {16'd0, mem_addr}, {16'd0, b.addr});
                if (b.wr) chk("bus_data", {24'd0, mem_data_out}, {24'd0, b.data});
            end
        end
        if (pc_load) begin
            got_load = 1'b1;
            load_cyc = cyc;
            total++;
            assert (load_q.size() > 0) else begin
                bad++;
                $error("FAIL load_unexpected observed=%0h expected=none", pc_load_value);
            end
            if (load_q.size() > 0) begin
                l = load_q.pop_front();
                chk("pc_value", {16'd0, pc_load_value}, {16'd0, l.pc});
                chk("sp_out", {24'd0, sp_out}, {24'd0, l.sp});
                chk("irq_ack", {28'd0, irq_ack}, {28'd0, l.ack});
                chk("src", {30'd0, active_src}, {30'd0, l.src});
                chk("sp_load_set_i", {30'd0, sp_load, set_i}, 32'd3);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(output int lcyc);
        got_load = 1'b0;
        lcyc = -1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (got_load) begin
                lcyc = load_cyc;
                break;
            end
        end
        total++;
        assert (lcyc >= 0) else begin
            bad++;
            $error("FAIL timeout observed=no_pc_load expected=pc_load");
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFD] = 8'h80; mem[16'hFFFB] = 8'h90;
        mem[16'hFFFF] = 8'hA0; mem[16'hFFE5] = 8'hB0;
        rst = 1'b1; nmi_n = 1'b1; brk_req = 1'b0; i_flag = 1'b1; insn_boundary = 1'b1;
        irq_n = '1; irq_mask = '1; pc_in = 16'h0; p_in = 8'h0; sp_in = 8'hFF;
        mem_ready = 1'b1; mem_data_in = 8'h0;

        // reset: outputs quiet while held, then vector fetch from FFFC/FFFD
        step(); step();
        chk("rst_busy", {31'd0, seq_busy}, 32'd0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
        exp_bus(0, 16'hFFFC, 8'h0); exp_bus(0, 16'hFFFD, 8'h0);
        exp_load(16'h8000, 8'hFD, '0, 2'd0);
        a = cyc;
        rst = 1'b0;
        #1;
        chk("rel_busy", {31'd0, seq_busy}, 32'd1);
        run(pl);
        chk("rst_latency", pl - a + 1, 32'd3);

        // NMI edge: three pushes, vector FFFA
        i_flag = 1'b0; pc_in = 16'h1234; p_in = 8'h21; sp_in = 8'hFF;
        exp_bus(1, 16'h01FF, 8'h12); exp_bus(1, 16'h01FE, 8'h34); exp_bus(1, 16'h01FD, 8'h21);
        exp_bus(0, 16'hFFFA, 8'h0); exp_bus(0, 16'hFFFB, 8'h0);
        exp_load(16'h9000, 8'hFC, '0, 2'd1);
        a = cyc;
        nmi_n = 1'b0;
        run(pl);
        chk("nmi_latency", pl - a, 32'd6);
        nmi_n = 1'b1;

        // IRQ masked by I, then vectored channel 2
        i_flag = 1'b1; irq_n = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("irq_blocked", {31'd0, seq_busy}, 32'd0);
        end
        pc_in = 16'h4321; p_in = 8'h35;
        exp_bus(1, 16'h01FF, 8'h43); exp_bus(1, 16'h01FE, 8'h21); exp_bus(1, 16'h01FD, 8'h25);
        exp_bus(0, 16'hFFE4, 8'h0); exp_bus(0, 16'hFFE5, 8'h0);
        exp_load(16'hB000, 8'hFC, 4'b0100, 2'd2);
        i_flag = 1'b0;
        run(pl);
        irq_n = '1; i_flag = 1'b1;
        step();

        // priority: NMI beats BRK beats IRQ on the same boundary
        i_flag = 1'b0; irq_n = 4'b1110; pc_in = 16'hABCD; p_in = 8'h05; sp_in = 8'h80;
        exp_bus(1, 16'h0180, 8'hAB); exp_bus(1, 16'h017F, 8'hCD); exp_bus(1, 16'h017E, 8'h25);
        exp_bus(0, 16'hFFFA, 8'h0); exp_bus(0, 16'hFFFB, 8'h0);
        exp_load(16'h9000, 8'h7D, '0, 2'd1);
        exp_bus(1, 16'h0180, 8'hAB); exp_bus(1, 16'h017F, 8'hCD); exp_bus(1, 16'h017E, 8'h35);
        exp_bus(0, 16'hFFFE, 8'h0); exp_bus(0, 16'hFFFF, 8'h0);
        exp_load(16'hA000, 8'h7D, '0, 2'd3);
        nmi_n = 1'b0; brk_req = 1'b1;
        step();
        brk_req = 1'b0; i_flag = 1'b1;
        run(pl);
        run(pl);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("irq_after_brk", {31'd0, seq_busy}, 32'd0);
        end
        irq_n = '1; nmi_n = 1'b1;
        step();

        // wait states on the PCL push
        pc_in = 16'h1234; p_in = 8'h21; sp_in = 8'hFF; hold_cnt = 3;
        exp_bus(1, 16'h01FF, 8'h12); exp_bus(1, 16'h01FE, 8'h34); exp_bus(1, 16'h01FD, 8'h21);
        exp_bus(0, 16'hFFFA, 8'h0); exp_bus(0, 16'hFFFB, 8'h0);
        exp_load(16'h9000, 8'hFC, '0, 2'd1);
        a = cyc;
        nmi_n = 1'b0;
        run(pl);
        chk("wait_latency", pl - a, 32'd9);
        nmi_n = 1'b1;
        step();

        // reset during PUSH_P: no P write, restart at FFFC
        abort_en = 1'b1;
        exp_bus(1, 16'h01FF, 8'h12); exp_bus(1, 16'h01FE, 8'h34);
        exp_bus(0, 16'hFFFC, 8'h0); exp_bus(0, 16'hFFFD, 8'h0);
        exp_load(16'h8000, 8'hFD, '0, 2'd0);
        nmi_n = 1'b0;
        for (int k = 0; k < 20 && !rst; k++) step();
        chk("abort_seen", {31'd0, rst}, 32'd1);
        step();
        chk("abort_rst_busy", {31'd0, seq_busy}, 32'd0);
        a = cyc;
        rst = 1'b0;
        run(pl);
        chk("abort_latency", pl - a + 1, 32'd3);

        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("load_q_empty", load_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
